// File: rtl/dmr_resp_distributor.sv
// ---------------------------------------------------------------------------
// dmr_resp_distributor
//
// Return-path companion to the DMR request comparator of a lockstep core
// pair. It watches the compared instruction and data OBI requests that reach
// the bus and replicates each bus response (gnt, rvalid, rdata) to every
// hart. It also tracks the number of in-flight transactions per channel.
// After a lockstep mismatch, a small recovery FSM drains the in-flight
// responses. The FSM also catches lost responses (timeout) and spurious or
// overflowing responses. It parks the pair in FAULT until software clears it.
//
// Response vectors are packed as {gnt, rvalid, rdata[DATA_W-1:0]}. The
// per-hart outputs are concatenated, with hart h at [h*RESP_W +: RESP_W].
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   bus_instr_req_i    instruction request (req) as driven to the bus
//   bus_instr_resp_i   instruction response from the bus
//   core_instr_resp_o  replicated instruction response, one slice per hart
//   bus_data_req_i     data request (req) as driven to the bus
//   bus_data_resp_i    data response from the bus
//   core_data_resp_o   replicated data response, one slice per hart
//   dmr_error_i        lockstep mismatch flag from the comparator
//   clear_i            software fault clear, honoured only in FAULT
//   fault_o            registered, high while in FAULT
//   fault_cause_o      sticky causes: [0] mismatch, [1] timeout, [2] protocol
// ---------------------------------------------------------------------------
module dmr_resp_distributor #(
    parameter int NHARTS          = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int DATA_W          = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         bus_instr_req_i,
    input  logic [DATA_W+1:0]            bus_instr_resp_i,
    output logic [NHARTS*(DATA_W+2)-1:0] core_instr_resp_o,
    input  logic                         bus_data_req_i,
    input  logic [DATA_W+1:0]            bus_data_resp_i,
    output logic [NHARTS*(DATA_W+2)-1:0] core_data_resp_o,
    input  logic                         dmr_error_i,
    input  logic                         clear_i,
    output logic                         fault_o,
    output logic [2:0]                   fault_cause_o
);

    localparam int RESP_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // Channel index 0 is the instruction channel, index 1 is the data channel.
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  outstCnt_q [2];
    logic [CNT_W-1:0]  outstCnt_d [2];
    logic [TMR_W-1:0]  waitTmr_q [2];
    logic [TMR_W-1:0]  waitTmr_d [2];
    logic              fault_q, fault_d;
    logic [2:0]        cause_q, cause_d;

    logic [1:0]        busReq, busGnt, busRvalid;
    logic [DATA_W-1:0] busRdata [2];
    logic [1:0]        fwdGnt, fwdRvalid;
    logic [DATA_W-1:0] fwdRdata [2];
    logic [1:0]        accept, spurious, overflow, waiting, timeout;
    logic              active, protoFault, timeoutFault, anyFault;

    // Response forwarding and per-channel bookkeeping. Masking is driven by
    // the registered state. The spurious-rvalid mask also looks at the
    // registered counter, so a response with nothing outstanding never
    // reaches the harts.
    always_comb begin
        busReq      = {bus_data_req_i, bus_instr_req_i};
        busGnt      = {bus_data_resp_i[DATA_W+1], bus_instr_resp_i[DATA_W+1]};
        busRvalid   = {bus_data_resp_i[DATA_W], bus_instr_resp_i[DATA_W]};
        busRdata[0] = bus_instr_resp_i[DATA_W-1:0];
        busRdata[1] = bus_data_resp_i[DATA_W-1:0];
        active      = (state_q != FAULT);

        for (int ch = 0; ch < 2; ch++) begin
            spurious[ch]  = active && busRvalid[ch] && (outstCnt_q[ch] == '0);
            fwdRvalid[ch] = active && busRvalid[ch] && (outstCnt_q[ch] != '0);
            fwdGnt[ch]    = (state_q == RUN) && busGnt[ch];
            fwdRdata[ch]  = active ? busRdata[ch] : '0;
            accept[ch]    = busReq[ch] && busGnt[ch];
            overflow[ch]  = active && accept[ch] && (outstCnt_q[ch] == CNT_MAX)
                            && !fwdRvalid[ch];
            waiting[ch]   = (outstCnt_q[ch] != '0) && !busRvalid[ch];
            timeout[ch]   = active && waiting[ch] && (waitTmr_q[ch] == TMR_LAST);

            outstCnt_d[ch] = outstCnt_q[ch];
            waitTmr_d[ch]  = waitTmr_q[ch];
            if (active) begin
                // A simultaneous accept and response leave the count unchanged.
                // An accept at the limit saturates the count.
                if (accept[ch] && !fwdRvalid[ch] && (outstCnt_q[ch] != CNT_MAX)) begin
                    outstCnt_d[ch] = outstCnt_q[ch] + CNT_ONE;
                end else if (!accept[ch] && fwdRvalid[ch]) begin
                    outstCnt_d[ch] = outstCnt_q[ch] - CNT_ONE;
                end

                if (!waiting[ch]) begin
                    waitTmr_d[ch] = '0;
                end else if (waitTmr_q[ch] != TMR_LAST) begin
                    waitTmr_d[ch] = waitTmr_q[ch] + TMR_ONE;
                end
            end
        end
    end

    // Recovery FSM and sticky cause collection. Any fault condition wins
    // over both the drain completion and a new mismatch. Every cause seen in
    // the same cycle is recorded.
    always_comb begin
        protoFault   = |spurious || |overflow;
        timeoutFault = |timeout;
        anyFault     = protoFault || timeoutFault;
        cause_d      = cause_q | {protoFault, timeoutFault, dmr_error_i};
        state_d      = state_q;

        case (state_q)
            RUN: begin
                if (anyFault) begin
                    state_d = FAULT;
                end else if (dmr_error_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (anyFault || ((outstCnt_d[0] == '0) && (outstCnt_d[1] == '0))) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (clear_i) begin
                    state_d = RUN;
                    cause_d = '0;
                    for (int ch = 0; ch < 2; ch++) begin
                        outstCnt_d[ch] = '0;
                        waitTmr_d[ch]  = '0;
                    end
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        fault_d = (state_d == FAULT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            fault_q <= 1'b0;
            cause_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                outstCnt_q[ch] <= '0;
                waitTmr_q[ch]  <= '0;
            end
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            for (int ch = 0; ch < 2; ch++) begin
                outstCnt_q[ch] <= outstCnt_d[ch];
                waitTmr_q[ch]  <= waitTmr_d[ch];
            end
        end
    end

    // Every hart receives an identical copy of each channel's response.
    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        assign core_instr_resp_o[h*RESP_W +: RESP_W] = {fwdGnt[0], fwdRvalid[0], fwdRdata[0]};
        assign core_data_resp_o[h*RESP_W +: RESP_W]  = {fwdGnt[1], fwdRvalid[1], fwdRdata[1]};
    end

    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_dmr_resp_distributor.sv
// ---------------------------------------------------------------------------
// tb_dmr_resp_distributor
//
// Directed bench for dmr_resp_distributor, built with TIMEOUT_CYCLES=4 and
// MAX_OUTSTANDING=2. Stimulus pushes the expected observations for each
// cycle into a scoreboard queue. An independent monitor pops and compares
// them in the middle of that cycle.
// ---------------------------------------------------------------------------
module tb_dmr_resp_distributor;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, iGnt, iRv, dReq, dGnt, dRv, err, clr;
    logic [31:0] iData, dData;
    logic [67:0] coreI, coreD;
    logic        fault;
    logic [2:0]  cause;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    dmr_resp_distributor #(
        .NHARTS(2), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(4), .DATA_W(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus_instr_req_i(iReq),
        .bus_instr_resp_i({iGnt, iRv, iData}),
        .core_instr_resp_o(coreI),
        .bus_data_req_i(dReq),
        .bus_data_resp_i({dGnt, dRv, dData}),
        .core_data_resp_o(coreD),
        .dmr_error_i(err),
        .clear_i(clr),
        .fault_o(fault),
        .fault_cause_o(cause)
    );

    // Free-running clock and a cycle index shared by stimulus and monitor.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Selects the observed value that an expectation refers to.
    function automatic logic [63:0] actual(input int sel);
        case (sel)
            0:       return 64'(coreI[33:0]);
            1:       return 64'(coreI[67:34]);
            2:       return 64'(coreD[33:0]);
            3:       return 64'(coreD[67:34]);
            4:       return 64'(fault);
            5:       return 64'(cause);
            6:       return 64'(dut.outstCnt_q[0]);
            default: return 64'(dut.outstCnt_q[1]);
        endcase
    endfunction

    // Monitor: on the falling edge, compare everything expected for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL %s: expected in cycle %0d, not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (actual(e.sel) !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", e.name, actual(e.sel), e.exp, cyc);
            end
        end
    end

    // Advance one cycle and return every bus-side input to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        iReq = 0; iGnt = 0; iRv = 0; iData = '0;
        dReq = 0; dGnt = 0; dRv = 0; dData = '0;
        err = 0; clr = 0;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
        sb.push_back('{cyc, name, sel, exp});
    endtask

    // Both harts must see the same response on a channel (0 instr, 1 data).
    task automatic expResp(input string name, input int ch, input logic g, input logic v,
                           input logic [31:0] d);
        checkOutput({name, "_h0"}, ch * 2, 64'({g, v, d}));
        checkOutput({name, "_h1"}, ch * 2 + 1, 64'({g, v, d}));
    endtask

    task automatic expFault(input string name, input logic f, input logic [2:0] c);
        checkOutput({name, "_fault"}, 4, 64'(f));
        checkOutput({name, "_cause"}, 5, 64'(c));
    endtask

    // Pulse clear in FAULT and confirm the next cycle is clean.
    task automatic clearFault(input string name);
        applyStimulus(); clr = 1;
        applyStimulus();
        expFault({name, "_clr"}, 1'b0, 3'b000);
        checkOutput({name, "_clr_icnt"}, 6, 64'd0);
        checkOutput({name, "_clr_dcnt"}, 7, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1;
        iReq = 0; iGnt = 0; iRv = 0; iData = '0;
        dReq = 0; dGnt = 0; dRv = 0; dData = '0;
        err = 0; clr = 0;
        repeat (2) @(posedge clk);

        // Reset state with combinational pass-through in RUN.
        applyStimulus(); rst = 0; iGnt = 1; iData = 32'hA5A5A5A5;
        expResp("rst_instr", 0, 1'b1, 1'b0, 32'hA5A5A5A5);
        expResp("rst_data", 1, 1'b0, 1'b0, 32'h0);
        expFault("rst", 1'b0, 3'b000);
        checkOutput("rst_icnt", 6, 64'd0);
        checkOutput("rst_dcnt", 7, 64'd0);

        // RUN path: two granted instruction reads, then their responses.
        applyStimulus(); iReq = 1; iGnt = 1;
        expResp("run_g1", 0, 1'b1, 1'b0, 32'h0);
        checkOutput("run_cnt0", 6, 64'd0);
        applyStimulus(); iReq = 1; iGnt = 1;
        checkOutput("run_cnt1", 6, 64'd1);
        applyStimulus(); iRv = 1; iData = 32'hDEADBEEF;
        expResp("run_r1", 0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("run_cnt2", 6, 64'd2);
        applyStimulus(); iRv = 1; iData = 32'h12345678;
        expResp("run_r2", 0, 1'b0, 1'b1, 32'h12345678);
        checkOutput("run_cnt3", 6, 64'd1);
        applyStimulus();
        checkOutput("run_cnt4", 6, 64'd0);
        expFault("run", 1'b0, 3'b000);

        // Mismatch drain on the data channel.
        applyStimulus(); dReq = 1; dGnt = 1;
        expResp("drn_g", 1, 1'b1, 1'b0, 32'h0);
        applyStimulus(); err = 1;
        expFault("drn_err", 1'b0, 3'b000);
        applyStimulus(); dGnt = 1; iGnt = 1;
        expResp("drn_dmask", 1, 1'b0, 1'b0, 32'h0);
        expResp("drn_imask", 0, 1'b0, 1'b0, 32'h0);
        expFault("drn_state", 1'b0, 3'b001);
        applyStimulus();
        applyStimulus(); dRv = 1; dData = 32'hCAFEF00D;
        expResp("drn_r", 1, 1'b0, 1'b1, 32'hCAFEF00D);
        checkOutput("drn_dcnt", 7, 64'd1);
        applyStimulus();
        expFault("drn_done", 1'b1, 3'b001);
        checkOutput("drn_dcnt0", 7, 64'd0);
        clearFault("drn");
        applyStimulus(); dGnt = 1;
        expResp("drn_pass", 1, 1'b1, 1'b0, 32'h0);

        // Timeout: one granted instruction request that never completes.
        applyStimulus(); iReq = 1; iGnt = 1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("to_wait%0d", i), 4, 64'd0);
        end
        applyStimulus(); iRv = 1; iGnt = 1; iData = 32'h11112222;
        expFault("to", 1'b1, 3'b010);
        expResp("to_late", 0, 1'b0, 1'b0, 32'h0);
        clearFault("to");

        // Spurious data response with nothing outstanding.
        applyStimulus(); dRv = 1; dData = 32'h55AA55AA;
        expResp("spur", 1, 1'b0, 1'b0, 32'h55AA55AA);
        expFault("spur_pre", 1'b0, 3'b000);
        applyStimulus();
        expFault("spur", 1'b1, 3'b100);
        clearFault("spur");

        // Accept plus response at the limit, then an overflowing accept.
        applyStimulus(); iReq = 1; iGnt = 1;
        applyStimulus(); iReq = 1; iGnt = 1;
        applyStimulus(); iReq = 1; iGnt = 1; iRv = 1; iData = 32'h0BADC0DE;
        expResp("ovf_both", 0, 1'b1, 1'b1, 32'h0BADC0DE);
        checkOutput("ovf_cnt_a", 6, 64'd2);
        applyStimulus(); iReq = 1; iGnt = 1;
        expResp("ovf_g", 0, 1'b1, 1'b0, 32'h0);
        checkOutput("ovf_cnt_b", 6, 64'd2);
        expFault("ovf_pre", 1'b0, 3'b000);
        applyStimulus();
        expFault("ovf", 1'b1, 3'b100);
        checkOutput("ovf_sat", 6, 64'd2);
        clearFault("ovf");

        // Reset while draining with both counters nonzero.
        applyStimulus(); iReq = 1; iGnt = 1;
        applyStimulus(); dReq = 1; dGnt = 1; err = 1;
        applyStimulus();
        expFault("rd_drain", 1'b0, 3'b001);
        checkOutput("rd_icnt1", 6, 64'd1);
        checkOutput("rd_dcnt1", 7, 64'd1);
        applyStimulus(); rst = 1;
        applyStimulus(); rst = 0; iGnt = 1;
        expFault("rd", 1'b0, 3'b000);
        checkOutput("rd_icnt", 6, 64'd0);
        checkOutput("rd_dcnt", 7, 64'd0);
        expResp("rd_pass", 0, 1'b1, 1'b0, 32'h0);

        repeat (3) applyStimulus();
        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard: %0d expectations never compared, required 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
